// File: rtl/mips_store_checker.sv
// Store checker between the MIPS core and Memory: owns the memory-port mux,
// compares each CPU store against a programmable expected table, and halts the CPU.
module mips_store_checker #(
    parameter int DW           = 32,
    parameter int AW           = 7,
    parameter int N            = 16,
    parameter int IW           = 4,
    parameter int CHECK_ADDR   = 0,
    parameter int STOP_ON_FAIL = 1,
    parameter int TIMEOUT      = 1024
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          start,
    input  logic          init_req,
    input  logic          ld_cs,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic          cpu_cs,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    output logic          mem_cs,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_bus,
    input  logic          exp_we,
    input  logic [IW-1:0] exp_idx,
    input  logic [DW-1:0] exp_data,
    input  logic [AW-1:0] exp_addr,
    input  logic [IW:0]   num_exp,
    output logic          cpu_rst,
    output logic          halt,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic          timeout,
    output logic [IW:0]   err_cnt,
    output logic [IW-1:0] first_err_idx,
    output logic [DW-1:0] last_data,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

    localparam logic [IW:0] N_W = (IW+1)'(N);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TO_LIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [TW-1:0] TO_LAST = TW'(TO_LIM);

    state_t        r_state;
    state_t        w_state_nxt;

    logic [DW-1:0] r_exp_data [N];
    logic [AW-1:0] r_exp_addr [N];

    logic [IW:0]   r_num;
    logic [IW:0]   r_idx;
    logic [IW:0]   r_err_cnt;
    logic [TW-1:0] r_timer;
    logic          r_we_q;
    logic          r_cpu_rst;
    logic          r_halt;
    logic          r_busy;
    logic          r_done;
    logic          r_pass;
    logic          r_timeout;
    logic [IW-1:0] r_first_err_idx;
    logic [DW-1:0] r_last_data;

    logic          w_wr;
    logic          w_store;
    logic          w_start;
    logic          w_data_mis;
    logic          w_addr_mis;
    logic          w_mis;
    logic          w_last;
    logic          w_to_fire;
    logic          w_end;
    logic [IW:0]   w_num_clamp;
    logic [IW:0]   w_idx_inc;
    logic [IW:0]   w_err_nxt;
    logic [IW-1:0] w_tidx;

    // A held write (multi-cycle cs&we) produces a single store event on its first cycle.
    assign w_wr        = cpu_cs & cpu_we;
    assign w_store     = w_wr & ~r_we_q;
    assign w_start     = start & (r_state != ST_RUN);
    assign w_num_clamp = (num_exp > N_W) ? N_W : num_exp;
    assign w_tidx      = r_idx[IW-1:0];
    assign w_idx_inc   = r_idx + (IW+1)'(1);
    assign w_data_mis  = (mem_bus != r_exp_data[w_tidx]);
    assign w_addr_mis  = (CHECK_ADDR != 0) && (cpu_addr != r_exp_addr[w_tidx]);
    assign w_mis       = w_data_mis | w_addr_mis;
    assign w_last      = (w_idx_inc == r_num);
    assign w_err_nxt   = r_err_cnt + (IW+1)'(w_mis);
    assign w_to_fire   = (TIMEOUT != 0) && !w_store && (r_timer == TO_LAST);
    assign w_end       = (w_state_nxt == ST_DONE) || (w_state_nxt == ST_FAIL);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Reaching num_exp takes priority over a stop-on-fail mismatch on the same edge.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_store) begin
                    if (w_last) begin
                        w_state_nxt = ST_DONE;
                    end else if (w_mis && (STOP_ON_FAIL != 0)) begin
                        w_state_nxt = ST_FAIL;
                    end
                end else if (w_to_fire) begin
                    w_state_nxt = ST_FAIL;
                end
            end
            default: begin
                if (w_start) begin
                    w_state_nxt = (w_num_clamp == '0) ? ST_DONE : ST_RUN;
                end
            end
        endcase
    end

    // Table is intentionally not reset so a rerun after RST needs no reload.
    always_ff @(posedge CLK) begin
        if ((r_state == ST_IDLE) && exp_we && ({1'b0, exp_idx} < N_W)) begin
            r_exp_data[exp_idx] <= exp_data;
            r_exp_addr[exp_idx] <= exp_addr;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_num           <= '0;
            r_idx           <= '0;
            r_err_cnt       <= '0;
            r_timer         <= '0;
            r_we_q          <= 1'b0;
            r_cpu_rst       <= 1'b1;
            r_halt          <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_pass          <= 1'b0;
            r_timeout       <= 1'b0;
            r_first_err_idx <= '0;
            r_last_data     <= '0;
        end else begin
            r_we_q <= w_wr;
            if (w_start) begin
                r_num           <= w_num_clamp;
                r_idx           <= '0;
                r_err_cnt       <= '0;
                r_timer         <= '0;
                r_timeout       <= 1'b0;
                r_first_err_idx <= '0;
                r_last_data     <= '0;
                if (w_num_clamp == '0) begin
                    r_cpu_rst <= 1'b0;
                    r_busy    <= 1'b0;
                    r_halt    <= 1'b1;
                    r_done    <= 1'b1;
                    r_pass    <= 1'b1;
                end else begin
                    // Restart from DONE/FAIL pulses the CPU reset for one cycle.
                    r_cpu_rst <= (r_state != ST_IDLE);
                    r_busy    <= 1'b1;
                    r_halt    <= 1'b0;
                    r_done    <= 1'b0;
                    r_pass    <= 1'b0;
                end
            end else if (r_state == ST_RUN) begin
                r_cpu_rst <= 1'b0;
                if (w_store) begin
                    r_last_data <= mem_bus;
                    r_idx       <= w_idx_inc;
                    r_timer     <= '0;
                    if (w_mis) begin
                        r_err_cnt <= w_err_nxt;
                        if (r_err_cnt == '0) begin
                            r_first_err_idx <= w_tidx;
                        end
                    end
                end else if ((TIMEOUT != 0) && !w_to_fire) begin
                    r_timer <= r_timer + TW'(1);
                end
                if (w_to_fire) begin
                    r_timeout <= 1'b1;
                end
                if (w_end) begin
                    r_busy <= 1'b0;
                    r_halt <= 1'b1;
                    r_done <= 1'b1;
                    r_pass <= (w_state_nxt == ST_DONE) && (w_err_nxt == '0);
                end
            end
        end
    end

    // After the run ends the CPU still reads, but its writes are blocked.
    always_comb begin
        mem_cs   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        case (r_state)
            ST_IDLE: begin
                if (init_req) begin
                    mem_cs   = ld_cs;
                    mem_we   = ld_we;
                    mem_addr = ld_addr;
                end
            end
            ST_RUN: begin
                mem_cs   = cpu_cs;
                mem_we   = cpu_we;
                mem_addr = cpu_addr;
            end
            default: begin
                mem_cs   = cpu_cs;
                mem_we   = 1'b0;
                mem_addr = cpu_addr;
            end
        endcase
    end

    assign cpu_rst       = r_cpu_rst;
    assign halt          = r_halt;
    assign busy          = r_busy;
    assign done          = r_done;
    assign pass          = r_pass;
    assign timeout       = r_timeout;
    assign err_cnt       = r_err_cnt;
    assign first_err_idx = r_first_err_idx;
    assign last_data     = r_last_data;
    assign dbg_state     = r_state;

endmodule
